// File: rtl/microphone_sampler_pkg.sv
// Shared types and elaboration-time helpers for the microphone sampler.
package microphone_sampler_pkg;

    // Frame sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Effective sample period. A frame occupies 2*frame_bits SCLK half
    // periods, plus at least one full SCLK period of CS-high recovery
    // before the next frame. Shorter requested periods are raised to that
    // floor so frames can never overlap.
    function automatic int clamp_period(input int sample_period,
                                        input int frame_bits,
                                        input int clk_div);
        int min_period;
        min_period = (2 * frame_bits + 2) * clk_div;
        return (sample_period < min_period) ? min_period : sample_period;
    endfunction

endpackage

// File: rtl/microphone_sampler_spi_sclk_gen.sv
// SCLK half-period divider. While active, it counts CLK_DIV clk cycles
// per half period and emits a one-cycle pulse at each boundary:
// rise_pulse when SCLK should go high, fall_pulse when it should go low.
// Dropping active returns the divider to its idle (SCLK low) phase.
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic             phase_q, phase_d;
    logic             tick;

    // Divider next state and edge pulses.
    always_comb begin
        // NOTE: every signal assigned here gets a value on every path
        // (defaults first), so no latch can be inferred.
        div_d   = div_q;
        phase_d = phase_q;
        tick    = active && (div_q == DIV_W'(CLK_DIV - 1));

        if (!active) begin
            div_d   = '0;
            phase_d = 1'b0;
        end else if (tick) begin
            div_d   = '0;
            phase_d = ~phase_q;
        end else begin
            div_d   = div_q + 1'b1;
        end

        rise_pulse = tick && !phase_q;
        fall_pulse = tick &&  phase_q;
    end

    // Divider state registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state updates use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            div_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/microphone_sampler.sv
// Periodic SPI (mode 0) reader for a serial microphone ADC. Once per
// sample period it lowers CS, clocks FRAME_BITS bits of CMD out on MOSI
// while capturing MISO, then publishes an 8-bit field of the received
// word on `sample` with a one-cycle `sample_valid` strobe.
module microphone_sampler
    import microphone_sampler_pkg::*;
#(
    parameter int                    CLK_DIV       = 4,
    parameter int                    FRAME_BITS    = 16,
    parameter int                    SAMPLE_PERIOD = 2000,
    parameter logic [FRAME_BITS-1:0] CMD           = 16'h0000,
    parameter int                    DATA_MSB      = 11
) (
    output logic       spi_clk,
    output logic       spi_mosi,
    output logic       spi_cs,
    input  logic       spi_miso,
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] sample,
    output logic       sample_valid
);

    localparam int PERIOD = clamp_period(SAMPLE_PERIOD, FRAME_BITS, CLK_DIV);
    localparam int CNT_W  = $clog2(PERIOD);
    localparam int BIT_W  = $clog2(FRAME_BITS + 1);
    // Only the low DATA_MSB+1 bits of the received word can reach the
    // sample field; older bits shift out of the top and are never needed.
    localparam int RX_W   = DATA_MSB + 1;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [RX_W-1:0]       rx_q, rx_d;
    logic                  cs_q, cs_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic [7:0]            sample_q, sample_d;
    logic                  valid_q, valid_d;

    logic                  sclk_active;
    logic                  sclk_rise;
    logic                  sclk_fall;
    logic                  last_bit;

    assign sclk_active = (state_q == ST_SHIFT);
    assign last_bit    = (bit_q == BIT_W'(FRAME_BITS - 1));

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk        (clk),
        .rst        (rst),
        .active     (sclk_active),
        .rise_pulse (sclk_rise),
        .fall_pulse (sclk_fall)
    );

    // Period counter, frame sequencer and shift-register next state.
    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        cs_d     = cs_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        sample_d = sample_q;
        valid_d  = 1'b0;

        // Free-running so CS falls exactly every PERIOD cycles.
        if (cnt_q == CNT_W'(PERIOD - 1)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_SHIFT;
                    cs_d    = 1'b0;
                    mosi_d  = CMD[FRAME_BITS-1];
                    tx_d    = CMD << 1;
                    rx_d    = '0;
                    bit_d   = '0;
                end
            end

            ST_SHIFT: begin
                if (sclk_rise) begin
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[RX_W-2:0], spi_miso};
                end
                if (sclk_fall) begin
                    sclk_d = 1'b0;
                    if (last_bit) begin
                        // Frame complete: release CS and publish the result.
                        state_d  = ST_DONE;
                        cs_d     = 1'b1;
                        mosi_d   = 1'b0;
                        sample_d = rx_q[DATA_MSB -: 8];
                        valid_d  = 1'b1;
                    end else begin
                        mosi_d = tx_q[FRAME_BITS-1];
                        tx_d   = tx_q << 1;
                        bit_d  = bit_q + 1'b1;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            cs_q     <= 1'b1;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            sample_q <= 8'h00;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            cs_q     <= cs_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

    assign spi_clk      = sclk_q;
    assign spi_mosi     = mosi_q;
    assign spi_cs       = cs_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;

endmodule

// File: tb/tb_microphone_sampler.sv
// Bench for microphone_sampler: an SPI slave model feeds MISO, a frame-level
// model predicts every output on every cycle, and directed checks pin the
// model to hand-computed values.
module tb_microphone_sampler;

    localparam int          CD       = 2;
    localparam int          FB       = 16;
    localparam int          P_A      = 100;
    localparam int          P_B      = 68;
    localparam int          FL       = 2 * FB * CD;   // CS low time: 64
    localparam int          DATA_MSB = 11;
    localparam logic [15:0] CMD_A    = 16'hA5F0;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       miso = 1'b0;

    logic       a_sclk, a_mosi, a_cs, a_valid;
    logic [7:0] a_sample;
    logic       b_sclk, b_mosi, b_cs, b_valid;
    logic [7:0] b_sample;

    int asserts = 0;
    int fails   = 0;
    int cyc     = 0;
    int edges   = 0;   // posedges since reset release

    logic [15:0] words [0:7] = '{16'h0ABC, 16'h0FFF, 16'h0000, 16'h0123,
                                 16'h0F0F, 16'h0C3A, 16'h0555, 16'h0AAA};
    logic [15:0] cmd_v = CMD_A;

    microphone_sampler #(
        .CLK_DIV(CD), .FRAME_BITS(FB), .SAMPLE_PERIOD(100),
        .CMD(CMD_A), .DATA_MSB(DATA_MSB)
    ) dut_a (
        .spi_clk(a_sclk), .spi_mosi(a_mosi), .spi_cs(a_cs), .spi_miso(miso),
        .clk(clk), .rst(rst), .sample(a_sample), .sample_valid(a_valid)
    );

    microphone_sampler #(
        .CLK_DIV(CD), .FRAME_BITS(FB), .SAMPLE_PERIOD(10),
        .CMD(16'h0000), .DATA_MSB(DATA_MSB)
    ) dut_b (
        .spi_clk(b_sclk), .spi_mosi(b_mosi), .spi_cs(b_cs), .spi_miso(1'b1),
        .clk(clk), .rst(rst), .sample(b_sample), .sample_valid(b_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // SPI slave: first bit valid at CS fall, next bit on each SCLK fall.
    int          slave_frame = 0;
    int          slave_pos   = 0;
    logic [15:0] slave_word  = '0;

    always @(posedge rst) slave_frame = 0;

    always @(negedge a_cs) begin
        slave_word  = words[slave_frame % 8];
        slave_frame = slave_frame + 1;
        slave_pos   = 15;
        miso        = slave_word[15];
    end

    always @(negedge a_sclk) begin
        if (slave_pos > 0) begin
            slave_pos = slave_pos - 1;
            miso      = slave_word[slave_pos];
        end else begin
            miso = 1'b0;
        end
    end

    // Per-cycle model comparison and frame-level event checks.
    logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_b_cs = 1'b1;
    int          last_fall = -1, last_b_fall = -1, rises = 0;
    logic [15:0] mosi_word = '0;

    always @(negedge clk) begin
        int n, ph, f;
        logic       e_cs, e_clk, e_mosi, e_valid;
        logic [7:0] e_sample;
        logic [15:0] w;

        if (rst || edges == 0) begin
            e_cs = 1'b1; e_clk = 1'b0; e_mosi = 1'b0; e_valid = 1'b0; e_sample = 8'h00;
        end else begin
            n  = edges - 1;
            ph = n % P_A;
            f  = n / P_A;
            e_cs    = !(ph < FL);
            e_clk   = (ph >= CD) && (ph < FL) && (((ph / CD) % 2) == 1);
            e_mosi  = (ph < FL) ? cmd_v[15 - ph / (2 * CD)] : 1'b0;
            e_valid = (ph == FL);
            if (ph >= FL) begin
                w = words[f % 8];
                e_sample = w[DATA_MSB -: 8];
            end else if (f >= 1) begin
                w = words[(f - 1) % 8];
                e_sample = w[DATA_MSB -: 8];
            end else begin
                e_sample = 8'h00;
            end
        end
        check("model_cs",     32'(a_cs),     32'(e_cs));
        check("model_sclk",   32'(a_sclk),   32'(e_clk));
        check("model_mosi",   32'(a_mosi),   32'(e_mosi));
        check("model_valid",  32'(a_valid),  32'(e_valid));
        check("model_sample", 32'(a_sample), 32'(e_sample));

        if (rst) begin
            last_fall   = -1;
            last_b_fall = -1;
            rises       = 0;
        end else begin
            if (prev_cs && !a_cs) begin
                if (last_fall >= 0) check("cs_period_a", 32'(cyc - last_fall), 32'(P_A));
                last_fall = cyc;
                rises     = 0;
                mosi_word = '0;
            end
            if (!prev_sclk && a_sclk) begin
                rises     = rises + 1;
                mosi_word = {mosi_word[14:0], a_mosi};
            end
            if (!prev_cs && a_cs) begin
                check("sclk_pulses_per_frame", 32'(rises), 32'd16);
                check("mosi_word", 32'(mosi_word), 32'h0000A5F0);
            end
            if (prev_b_cs && !b_cs) begin
                if (last_b_fall >= 0) check("cs_period_clamped", 32'(cyc - last_b_fall), 32'(P_B));
                last_b_fall = cyc;
            end
            if (b_valid) check("clamped_sample", 32'(b_sample), 32'h000000FF);
        end
        prev_cs   = a_cs;
        prev_sclk = a_sclk;
        prev_b_cs = b_cs;
    end

    // Wait until the negedge following edge index `target` after release.
    task automatic wait_n(input int target);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!rst && edges - 1 == target) return;
        end
        check("wait_timeout", 32'(edges - 1), 32'(target));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs",     32'(a_cs),     32'd1);
        check("rst_sclk",   32'(a_sclk),   32'd0);
        check("rst_mosi",   32'(a_mosi),   32'd0);
        check("rst_sample", 32'(a_sample), 32'h00);
        check("rst_valid",  32'(a_valid),  32'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        wait_n(0);
        check("first_cs_fall", 32'(a_cs), 32'd0);
        check("first_mosi",    32'(a_mosi), 32'd1);
        wait_n(1);
        check("sclk_low_at_1", 32'(a_sclk), 32'd0);
        wait_n(2);
        check("first_sclk_rise", 32'(a_sclk), 32'd1);
        wait_n(63);
        check("cs_still_low_63", 32'(a_cs), 32'd0);
        wait_n(64);
        check("sample_0abc", 32'(a_sample), 32'h000000AB);
        check("valid_at_64", 32'(a_valid),  32'd1);
        check("cs_rise_64",  32'(a_cs),     32'd1);
        wait_n(65);
        check("valid_one_cycle", 32'(a_valid), 32'd0);
        wait_n(163);
        check("sample_held", 32'(a_sample), 32'h000000AB);
        wait_n(164);
        check("sample_0fff", 32'(a_sample), 32'h000000FF);
        wait_n(264);
        check("sample_0000", 32'(a_sample), 32'h00000000);
        wait_n(364);
        check("sample_0123", 32'(a_sample), 32'h00000012);

        // Abort frame 5 at its cycle 30.
        wait_n(530);
        #1 rst = 1'b1;
        #1;
        check("abort_cs",     32'(a_cs),     32'd1);
        check("abort_sclk",   32'(a_sclk),   32'd0);
        check("abort_sample", 32'(a_sample), 32'h00);
        check("abort_valid",  32'(a_valid),  32'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        wait_n(0);
        check("restart_cs_fall", 32'(a_cs), 32'd0);
        wait_n(64);
        check("restart_sample", 32'(a_sample), 32'h000000AB);
        wait_n(180);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
